// File: rtl/fsm.sv
// Alarm-clock mode/field-select controller: three debounced buttons toggle adjust
// mode and rotate a one-hot enable across the four adjustable time fields.
module fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic       left,
    input  logic       right,
    input  logic       center,
    output logic       adjust,
    output logic [3:0] EN
);

    typedef enum logic [2:0] {
        NORMAL   = 3'd0,
        ADJ_CMIN = 3'd1,
        ADJ_CHR  = 3'd2,
        ADJ_AMIN = 3'd3,
        ADJ_AHR  = 3'd4
    } state_t;

    state_t state;
    state_t next_state;

    logic lp;
    logic rp;
    logic cp;
    logic l_press;
    logic r_press;
    logic c_press;

    // Previous levels reset to 1 so a button held through reset must be released first.
    always_ff @(posedge clk) begin
        if (rst) begin
            lp <= 1'b1;
            rp <= 1'b1;
            cp <= 1'b1;
        end else begin
            lp <= left;
            rp <= right;
            cp <= center;
        end
    end

    assign l_press = left   & ~lp;
    assign r_press = right  & ~rp;
    assign c_press = center & ~cp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= NORMAL;
        end else begin
            state <= next_state;
        end
    end

    // Center outranks left/right; left and right together cancel each other.
    always_comb begin
        next_state = state;
        case (state)
            NORMAL: begin
                if (c_press) next_state = ADJ_CMIN;
            end
            ADJ_CMIN: begin
                if (c_press)                  next_state = NORMAL;
                else if (r_press && !l_press) next_state = ADJ_CHR;
                else if (l_press && !r_press) next_state = ADJ_AHR;
            end
            ADJ_CHR: begin
                if (c_press)                  next_state = NORMAL;
                else if (r_press && !l_press) next_state = ADJ_AMIN;
                else if (l_press && !r_press) next_state = ADJ_CMIN;
            end
            ADJ_AMIN: begin
                if (c_press)                  next_state = NORMAL;
                else if (r_press && !l_press) next_state = ADJ_AHR;
                else if (l_press && !r_press) next_state = ADJ_CHR;
            end
            ADJ_AHR: begin
                if (c_press)                  next_state = NORMAL;
                else if (r_press && !l_press) next_state = ADJ_CMIN;
                else if (l_press && !r_press) next_state = ADJ_AMIN;
            end
            default: next_state = NORMAL;
        endcase
    end

    always_comb begin
        adjust = 1'b0;
        EN     = 4'b0000;
        case (state)
            ADJ_CMIN: begin adjust = 1'b1; EN = 4'b0001; end
            ADJ_CHR:  begin adjust = 1'b1; EN = 4'b0010; end
            ADJ_AMIN: begin adjust = 1'b1; EN = 4'b0100; end
            ADJ_AHR:  begin adjust = 1'b1; EN = 4'b1000; end
            default:  begin adjust = 1'b0; EN = 4'b0000; end
        endcase
    end

endmodule

// File: tb/tb_fsm.sv
// Directed-vector bench for the alarm-clock mode controller; expected {adjust, EN}
// values below are worked out by hand from the button sequence.
module tb_fsm;

    logic       clk;
    logic       rst;
    logic       left;
    logic       right;
    logic       center;
    logic       adjust;
    logic [3:0] EN;

    int vectors;
    int miscompares;

    fsm dut (
        .clk    (clk),
        .rst    (rst),
        .left   (left),
        .right  (right),
        .center (center),
        .adjust (adjust),
        .EN     (EN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive levels, then let the given number of rising edges pass; returns 1 time unit after the last one.
    task automatic applyStimulus(input logic r_in, input logic l_in, input logic rt_in,
                                 input logic c_in, input int cycles);
        rst    = r_in;
        left   = l_in;
        right  = rt_in;
        center = c_in;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [4:0] observed,
                               input logic [4:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got adjust/EN=%b_%b, expected %b_%b",
                     tag, observed[4], observed[3:0], expected[4], expected[3:0]);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1; left = 1'b0; right = 1'b0; center = 1'b0;

        applyStimulus(1, 0, 0, 0, 5);
        checkOutput("reset", {adjust, EN}, 5'b0_0000);
        applyStimulus(0, 0, 0, 0, 2);
        checkOutput("idle", {adjust, EN}, 5'b0_0000);

        applyStimulus(0, 0, 1, 0, 10);
        checkOutput("right_in_normal", {adjust, EN}, 5'b0_0000);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 5);
        checkOutput("left_in_normal", {adjust, EN}, 5'b0_0000);
        applyStimulus(0, 0, 0, 0, 1);

        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("center_enter", {adjust, EN}, 5'b1_0001);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("center_release", {adjust, EN}, 5'b1_0001);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("center_exit", {adjust, EN}, 5'b0_0000);
        applyStimulus(0, 0, 0, 0, 1);

        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("center_hold_edge", {adjust, EN}, 5'b1_0001);
        applyStimulus(0, 0, 0, 1, 9);
        checkOutput("center_hold_10", {adjust, EN}, 5'b1_0001);
        applyStimulus(0, 0, 0, 0, 1);

        applyStimulus(0, 0, 1, 0, 1); checkOutput("right1", {adjust, EN}, 5'b1_0010);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 1); checkOutput("right2", {adjust, EN}, 5'b1_0100);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 1); checkOutput("right3", {adjust, EN}, 5'b1_1000);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 1); checkOutput("right_wrap", {adjust, EN}, 5'b1_0001);
        applyStimulus(0, 0, 0, 0, 1);

        applyStimulus(0, 1, 0, 0, 1); checkOutput("left_wrap", {adjust, EN}, 5'b1_1000);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 1); checkOutput("left2", {adjust, EN}, 5'b1_0100);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 1); checkOutput("left3", {adjust, EN}, 5'b1_0010);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 1); checkOutput("left4", {adjust, EN}, 5'b1_0001);
        applyStimulus(0, 0, 0, 0, 1);

        applyStimulus(0, 0, 1, 0, 3); checkOutput("right_hold", {adjust, EN}, 5'b1_0010);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 1, 1, 0, 1); checkOutput("left_right_cancel", {adjust, EN}, 5'b1_0010);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 1, 1); checkOutput("center_beats_right", {adjust, EN}, 5'b0_0000);
        applyStimulus(0, 0, 0, 0, 1);

        applyStimulus(0, 0, 0, 1, 1); checkOutput("reenter", {adjust, EN}, 5'b1_0001);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 1); checkOutput("to_amin", {adjust, EN}, 5'b1_0100);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 1, 1); checkOutput("reset_mid_adjust", {adjust, EN}, 5'b0_0000);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 1); checkOutput("reenter_after_reset", {adjust, EN}, 5'b1_0001);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 1); checkOutput("exit_again", {adjust, EN}, 5'b0_0000);

        applyStimulus(1, 0, 0, 1, 2); checkOutput("center_held_in_reset", {adjust, EN}, 5'b0_0000);
        applyStimulus(0, 0, 0, 1, 3); checkOutput("center_held_past_reset", {adjust, EN}, 5'b0_0000);
        applyStimulus(0, 0, 0, 0, 1); checkOutput("center_released", {adjust, EN}, 5'b0_0000);
        applyStimulus(0, 0, 0, 1, 1); checkOutput("center_new_press", {adjust, EN}, 5'b1_0001);
        applyStimulus(0, 0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
